// File: rtl/pulse_to_level_if.sv
// Event/level bundle between game logic and the pulse stretcher.
interface pulse_to_level_if;
    logic pulse;
    logic level;
    logic busy;
    logic pending;
    logic dropped;

    modport master (
        output pulse,
        input  level,
        input  busy,
        input  pending,
        input  dropped
    );

    modport slave (
        input  pulse,
        output level,
        output busy,
        output pending,
        output dropped
    );
endinterface

// File: rtl/pulse_to_level.sv
// Pulse stretcher: one-cycle events become HOLD_CYCLES-long levels separated by GAP_CYCLES low.
// Optional PULSE_TO_LEVEL_RETRIGGER_EN: an event during HOLD extends the high period instead of queueing.
module pulse_to_level #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             reset,
    pulse_to_level_if.slave  bus
);
    localparam int unsigned MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pending_q, pending_d;
    logic             dropped_q, dropped_d;
    logic             queue_event;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            count_q   <= '0;
            pending_q <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            dropped_q <= dropped_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pending_d   = pending_q;
        dropped_d   = 1'b0;
        queue_event = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.pulse) begin
                    state_d = StHold;
                    count_d = HOLD_LOAD;
                end
            end
            StHold: begin
`ifdef PULSE_TO_LEVEL_RETRIGGER_EN
                if (bus.pulse) begin
                    count_d = HOLD_LOAD;
                end else if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end else if (GAP_CYCLES > 0) begin
                    state_d = StGap;
                    count_d = GAP_LOAD;
                end else begin
                    // No gap configured: only a pending event can follow directly.
                    if (pending_q) begin
                        count_d   = HOLD_LOAD;
                        pending_d = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end
`else
                if (count_q != '0) begin
                    count_d     = count_q - CNT_W'(1);
                    queue_event = 1'b1;
                end else if (GAP_CYCLES > 0) begin
                    state_d     = StGap;
                    count_d     = GAP_LOAD;
                    queue_event = 1'b1;
                end else if (pending_q || bus.pulse) begin
                    count_d   = HOLD_LOAD;
                    pending_d = pending_q && bus.pulse;
                end else begin
                    state_d = StIdle;
                end
`endif
            end
            StGap: begin
                if (count_q != '0) begin
                    count_d     = count_q - CNT_W'(1);
                    queue_event = 1'b1;
                end else if (pending_q || bus.pulse) begin
                    // A pulse arriving alongside a served pending event becomes the new pending.
                    state_d   = StHold;
                    count_d   = HOLD_LOAD;
                    pending_d = pending_q && bus.pulse;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                count_d = '0;
            end
        endcase

        if (queue_event && bus.pulse) begin
            if (pending_q) begin
                dropped_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    assign bus.level   = (state_q == StHold);
    assign bus.busy    = (state_q != StIdle);
    assign bus.pending = pending_q;
    assign bus.dropped = dropped_q;
endmodule
